ring_fifo: RTL and testbench
============================

# ring_fifo

Parametrised circular-buffer FIFO. It replaces the shift-register queue in the reusable blocks library. Storage is a pointer-addressed RAM array, so data never shifts. It adds simultaneous push/pop at full and at empty, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between pipeline stages wherever decoupling buffering is needed: fetch queue, memory request queues, and similar.

## Interface
- WIDTH, 32, data word width in bits (≥1).
- DEPTH, 8, number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-1, almost_full asserts when used_pos ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, almost_empty asserts when used_pos ≤ AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all stored entries.
- d_in  in  WIDTH  write data.
- we  in  1  write (push) request.
- se  in  1  shift (pop) request.
- d_out  out  WIDTH  head entry; 0 when empty.
- used_pos  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- full  out  1  used_pos == DEPTH.
- empty  out  1  used_pos == 0.
- almost_full  out  1  used_pos ≥ AF_LEVEL.
- almost_empty  out  1  used_pos ≤ AE_LEVEL.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a shift was rejected.
- err_clr  in  1  clears overflow/underflow.

## Operation
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH with natural overflow.
  - count register driving used_pos.
  - mem[DEPTH] of WIDTH bits.
- Status outputs (full, empty, almost_full, almost_empty) are decoded combinationally from count only.
- Read path: d_out = empty ? 0 : mem[rd_ptr], combinational. There is no output register and no fall-through of d_in.
- Accept rules, evaluated on the pre-edge state:
  - write_ok = we & (~full | se). A push while full is accepted only with a simultaneous pop.
  - shift_ok = se & ~empty. A pop while empty is always rejected, even if we is high.
- Effects of an accepted write: mem[wr_ptr] ← d_in; wr_ptr+1.
- Effects of an accepted shift: rd_ptr+1.
- Count update: count + write_ok − shift_ok. Both accepted leaves count unchanged.
- Errors:
  - overflow ← 1 on we & ~write_ok.
  - underflow ← 1 on se & ~shift_ok.
  - err_clr clears both flags. If a new error occurs in the same cycle as err_clr, setting wins.
- Flush:
  - Sets wr_ptr, rd_ptr and count to 0.
  - Overrides we/se in that cycle; no write or shift occurs and no error is flagged.
  - Leaves the error flags and mem contents untouched.
- Reset:
  - Clears pointers, count, overflow and underflow. mem is not cleared.
  - Reset has priority over flush, err_clr, we and se.
  - Reset mid-stream drops all data.

## Timing
- Reset values: used_pos=0, empty=1, full=0, almost_empty=1 (since AE_LEVEL ≥ 0), almost_full=0 (since AF_LEVEL ≥ 1), overflow=0, underflow=0, d_out=0.
- Write latency: a write accepted at edge N appears on d_out (if it is the head), used_pos and flags immediately after edge N. Write-to-read latency is 1 cycle.
- Pop: d_out shows the next entry immediately after the popping edge.
- Flush and err_clr take effect at the edge they are sampled on; outputs update after that edge.
- Wrap-around: pointers roll DEPTH-1→0 with no bubble. Sustained simultaneous push/pop at full runs at 1 word/cycle indefinitely.
- No combinational path from we or se to any output. d_out depends only on registers.

## Test plan
(WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
- Reset then push 0x11,0x22,0x33,0x44 on 4 consecutive cycles:
  - used_pos goes 1,2,3,4.
  - almost_full rises after the 3rd push; full rises after the 4th.
  - d_out=0x11 throughout.
- From full, one cycle of we=1 with d_in=0x55 (se=0):
  - overflow=1, used_pos stays 4, contents unchanged.
  - Then err_clr: overflow=0.
- From full, 6 cycles of we=se=1 with d_in=0x60..0x65:
  - used_pos stays 4 throughout.
  - Popped sequence is 0x11,0x22,0x33,0x44,0x60,0x61 (pointer wrap exercised).
- From empty, one cycle of we=se=1 with d_in=0xA5:
  - used_pos=1, d_out=0xA5, underflow=1.
  - Then se alone: empty=1, d_out=0.
- With 3 entries stored, assert flush together with we=1 and d_in=0x77:
  - used_pos=0, empty=1, no write stored.
  - Error flags unchanged.
- Mid-stream, with 2 entries stored and underflow=1, assert rst with we=se=1:
  - Next cycle: all outputs at reset values.
  - The first subsequent push 0x99 appears on d_out.

Source files
------------

// File: rtl/ring_fifo.sv
// ring_fifo: pointer-addressed circular-buffer FIFO.
//
// Entries never move. wr_ptr/rd_ptr index a RAM array and wrap naturally
// modulo DEPTH. A separate count register holds the occupancy, and all status
// flags are decoded from that count. d_out is a combinational read of the head
// entry and is forced to 0 when the FIFO is empty.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           drop all entries (pointers/count to 0, flags and mem kept)
//   d_in, we        push data / push request
//   se              pop request
//   d_out           head entry (0 when empty)
//   used_pos        occupancy 0..DEPTH
//   full, empty     occupancy == DEPTH / == 0
//   almost_full     used_pos >= AF_LEVEL
//   almost_empty    used_pos <= AE_LEVEL
//   overflow        sticky: a push was rejected
//   underflow       sticky: a pop was rejected
//   err_clr         clears overflow/underflow (a new error in the same cycle wins)
module ring_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         d_in,
    input  logic                     we,
    input  logic                     se,
    output logic [WIDTH-1:0]         d_out,
    output logic [$clog2(DEPTH):0]   used_pos,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic write_ok;
    logic shift_ok;
    logic do_write;
    logic do_shift;

    // Status comes only from the count register, so no input reaches an output
    // combinationally.
    assign used_pos     = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign d_out        = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        // A push while full goes through only if the head is leaving in the
        // same cycle. A pop while empty never goes through, because there is
        // no fall-through from d_in.
        write_ok = we & (~full | se);
        shift_ok = se & ~empty;

        // Flush suppresses both the transfer and any error report.
        do_write = write_ok & ~flush;
        do_shift = shift_ok & ~flush;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_shift) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, do_write} - {{PW{1'b0}}, do_shift};
        end

        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // A new error is applied after the clear, so setting wins.
        if (~flush & we & ~write_ok) overflow_d  = 1'b1;
        if (~flush & se & ~shift_ok) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset. Entries are only visible through count, so stale
    // contents are harmless.
    always_ff @(posedge clk) begin
        if (~rst & do_write) mem[wr_ptr_q] <= d_in;
    end

endmodule

// File: tb/tb_ring_fifo.sv
module tb_ring_fifo;

    logic       clk = 1'b0;
    logic       rst, flush, we, se, err_clr;
    logic [7:0] d_in, d_out;
    logic [2:0] used_pos;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int total = 0;
    int bad   = 0;

    ring_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .d_in(d_in), .we(we), .se(se),
        .d_out(d_out), .used_pos(used_pos), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, and outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; we = 0; se = 0; err_clr = 0; d_in = 8'h00;
    endtask

    task automatic test_reset();
        idle(); rst = 1; step(); step(); rst = 0;
        total++; if (used_pos !== 3'd0)    begin bad++; $display("FAIL reset_used got=%0d exp=0", used_pos); end
        total++; if (empty !== 1'b1)       begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)        begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
        total++; if (d_out !== 8'h00)      begin bad++; $display("FAIL reset_dout got=%h exp=00", d_out); end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            we = 1; d_in = vals[i]; step();
            total++; if (used_pos !== 3'(i + 1)) begin bad++; $display("FAIL fill_used[%0d] got=%0d exp=%0d", i, used_pos, i + 1); end
            total++; if (almost_full !== (i >= 2)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, i >= 2); end
            total++; if (full !== (i == 3))      begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 3); end
            total++; if (almost_empty !== (i == 0)) begin bad++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, i == 0); end
            total++; if (d_out !== 8'h11)        begin bad++; $display("FAIL fill_dout[%0d] got=%h exp=11", i, d_out); end
        end
        we = 0;
    endtask

    task automatic test_overflow();
        we = 1; d_in = 8'h55; step(); we = 0;
        total++; if (overflow !== 1'b1)  begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (used_pos !== 3'd4)  begin bad++; $display("FAIL ovf_used got=%0d exp=4", used_pos); end
        total++; if (d_out !== 8'h11)    begin bad++; $display("FAIL ovf_dout got=%h exp=11", d_out); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL ovf_unf got=%b exp=0", underflow); end
        err_clr = 1; step(); err_clr = 0;
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] popped [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h60, 8'h61};
        logic [7:0] rest   [4] = '{8'h62, 8'h63, 8'h64, 8'h65};
        for (int k = 0; k < 6; k++) begin
            we = 1; se = 1; d_in = 8'h60 + 8'(k);
            total++; if (d_out !== popped[k]) begin bad++; $display("FAIL wrap_pop[%0d] got=%h exp=%h", k, d_out, popped[k]); end
            step();
            total++; if (used_pos !== 3'd4)   begin bad++; $display("FAIL wrap_used[%0d] got=%0d exp=4", k, used_pos); end
        end
        we = 0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", overflow); end
        for (int k = 0; k < 4; k++) begin
            total++; if (d_out !== rest[k]) begin bad++; $display("FAIL drain_pop[%0d] got=%h exp=%h", k, d_out, rest[k]); end
            step();
        end
        se = 0;
        total++; if (empty !== 1'b1 || d_out !== 8'h00) begin bad++; $display("FAIL drain_empty got=%b/%h exp=1/00", empty, d_out); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL drain_unf got=%b exp=0", underflow); end
    endtask

    task automatic test_empty_pushpop();
        we = 1; se = 1; d_in = 8'hA5; step(); we = 0;
        total++; if (used_pos !== 3'd1) begin bad++; $display("FAIL epp_used got=%0d exp=1", used_pos); end
        total++; if (d_out !== 8'hA5)   begin bad++; $display("FAIL epp_dout got=%h exp=a5", d_out); end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL epp_unf got=%b exp=1", underflow); end
        step(); se = 0;
        total++; if (empty !== 1'b1 || d_out !== 8'h00) begin bad++; $display("FAIL epp_pop got=%b/%h exp=1/00", empty, d_out); end
        // Clearing while a new underflow happens: the new error wins.
        err_clr = 1; se = 1; step(); se = 0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL clr_vs_set got=%b exp=1", underflow); end
        step(); err_clr = 0;
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", underflow); end
    endtask

    task automatic test_flush();
        se = 1; step(); se = 0;   // set underflow so flush can be seen leaving it alone
        for (int i = 0; i < 3; i++) begin we = 1; d_in = 8'(i + 1); step(); end
        total++; if (used_pos !== 3'd3) begin bad++; $display("FAIL fl_pre got=%0d exp=3", used_pos); end
        flush = 1; we = 1; d_in = 8'h77; step(); flush = 0; we = 0;
        total++; if (used_pos !== 3'd0) begin bad++; $display("FAIL fl_used got=%0d exp=0", used_pos); end
        total++; if (empty !== 1'b1 || d_out !== 8'h00) begin bad++; $display("FAIL fl_empty got=%b/%h exp=1/00", empty, d_out); end
        total++; if ({overflow, underflow} !== 2'b01) begin bad++; $display("FAIL fl_err got=%b%b exp=01", overflow, underflow); end
        we = 1; d_in = 8'h88; step(); we = 0;
        total++; if (d_out !== 8'h88 || used_pos !== 3'd1) begin bad++; $display("FAIL fl_after got=%h/%0d exp=88/1", d_out, used_pos); end
    endtask

    task automatic test_reset_mid();
        we = 1; d_in = 8'h89; step(); we = 0;
        total++; if (used_pos !== 3'd2 || underflow !== 1'b1) begin bad++; $display("FAIL rm_pre got=%0d/%b exp=2/1", used_pos, underflow); end
        rst = 1; we = 1; se = 1; d_in = 8'hEE; step(); idle();
        total++; if (used_pos !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rm_cnt got=%0d/%b/%b exp=0/1/0", used_pos, empty, full); end
        total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin bad++; $display("FAIL rm_almost got=%b/%b exp=1/0", almost_empty, almost_full); end
        total++; if ({overflow, underflow} !== 2'b00 || d_out !== 8'h00) begin bad++; $display("FAIL rm_err got=%b%b/%h exp=00/00", overflow, underflow, d_out); end
        we = 1; d_in = 8'h99; step(); we = 0;
        total++; if (d_out !== 8'h99 || used_pos !== 3'd1) begin bad++; $display("FAIL rm_push got=%h/%0d exp=99/1", d_out, used_pos); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_overflow();
        test_wrap();
        test_empty_pushpop();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
